mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences and shares the single-ported unified memory of the multicycle RISC-V core between the instruction-fetch requester (IF state) and the data requester (LW/SW MEM states). Each requester raises a level request with stable command fields and receives a one-cycle acknowledge with registered read data. The block owns the memory strobes, so the control FSM never drives memory pins directly. It also absorbs the memory's fixed read latency.

## Interface
- ADDR_W, 12: byte-address width on requester and memory sides.
- MEM_LAT, 2: cycles from the access cycle to valid M_DIN; legal range 1..15.

- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request, held until I_ACK.
- I_ADDR  in  ADDR_W  fetch address.
- I_RDATA  out  32  registered fetched word.
- I_ACK  out  1  one-cycle completion pulse.
- D_REQ  in  1  data request, held until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_BE  in  4  byte enables for stores.
- D_ADDR  in  ADDR_W  data address.
- D_WDATA  in  32  store data.
- D_RDATA  out  32  registered load word.
- D_ACK  out  1  one-cycle completion pulse.
- M_CSN  out  1  memory chip select, active low.
- M_WEN  out  1  memory write enable, active low.
- M_BE  out  4  memory byte enables.
- M_ADDR  out  ADDR_W  memory address.
- M_DOUT  out  32  memory write data.
- M_DIN  in  32  memory read data.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: requests are sampled here only. Grant the winner and latch its command into the command registers, then go to ACCESS.
  - ACCESS: drive M_CSN=0, M_ADDR, M_BE and M_WEN/M_DOUT from the latched command for exactly one cycle. A store goes to RESP. A load loads the latency counter with MEM_LAT-1 and goes to WAIT.
  - WAIT: decrement the counter. At counter 0, capture M_DIN into the granted requester's RDATA and go to RESP.
  - RESP: pulse the granted requester's ACK, then return to IDLE.
- Memory strobes outside ACCESS: M_CSN=1, M_WEN=1. M_ADDR, M_BE and M_DOUT hold their last values.
- Loads and fetches drive M_BE=4'b1111. Stores drive D_BE.
- A store with D_BE=4'b0000 keeps M_CSN=1 during ACCESS but still completes the handshake.
- Arbitration: fixed priority, data over fetch.
- I_RDATA is written only by fetches and D_RDATA only by loads. Each holds its value until overwritten.
- A request withdrawn before its ACK is a protocol violation. The access still completes and ACK still pulses.

## Timing
- A request seen in IDLE at cycle t produces ACCESS at t+1.
- Load or fetch ACK arrives at t+MEM_LAT+2. Store ACK arrives at t+2.
- RDATA is valid in the ACK cycle and stays stable afterwards.
- A requester must deassert REQ in the cycle after ACK. The next grant happens no earlier than the IDLE cycle following RESP.
- Reset values: I_ACK=0, D_ACK=0, I_RDATA=0, D_RDATA=0, M_CSN=1, M_WEN=1, M_BE=0, M_ADDR=0, M_DOUT=0, BUSY=0, state IDLE, last-grant=fetch.
- RST asserted in any state takes effect next edge. It abandons the in-flight access, suppresses its ACK and discards M_DIN.
- Simultaneous I_REQ and D_REQ in IDLE are resolved by the arbitration rule. The loser stays pending and is granted at the next IDLE.

## Configuration
- MEM_ROUND_ROBIN_EN
  - Defined: on a tie, grant the requester that was not granted last. The last-grant register updates on every grant and resets to fetch, so the first tie goes to data.
  - Undefined: fixed data-over-fetch priority; the last-grant register is not implemented.
- With no tie, both modes grant the sole requester.

## Test plan
- MEM_LAT=2, I_REQ at cycle 5, I_ADDR=0x010, M_DIN=0x00A00093 during the capture cycle -> M_CSN=0 only in cycle 6; I_ACK pulses in cycle 9 with I_RDATA=0x00A00093.
- Store with D_ADDR=0x204, D_BE=4'b0011, D_WDATA=0xDEADBEEF -> one ACCESS cycle with M_WEN=0, M_BE=0011, M_DOUT=0xDEADBEEF; D_ACK 2 cycles after grant.
- I_REQ and D_REQ raised in the same cycle and held -> data is served first, then fetch. With MEM_ROUND_ROBIN_EN, a second tie grants fetch first.
- Store with D_BE=0 -> M_CSN stays 1 throughout; D_ACK still pulses 2 cycles after grant.
- RST raised during WAIT of a load -> next cycle all outputs are at reset values; no D_ACK; BUSY=0.
- MEM_LAT=1 and MEM_LAT=15 back-to-back fetches -> ACK spacing of 4 and 18 cycles respectively; RDATA matches M_DIN.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and data load/store.
// Optional MEM_ROUND_ROBIN_EN: ties alternate between requesters instead of data-first.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [31:0]       I_RDATA,
  output logic              I_ACK,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic [31:0]       D_RDATA,
  output logic              D_ACK,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_DOUT,
  input  logic [31:0]       M_DIN,
  output logic              BUSY,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester holds REQ and its command fields stable until a
  // one-cycle ACK; RDATA is valid in the ACK cycle and held until the next
  // completion of the same kind. REQ must be low in the cycle after ACK.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_gnt_data;
  logic              r_cmd_we;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_m_csn;
  logic              r_m_wen;
  logic [3:0]        r_m_be;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       r_m_dout;

  logic              w_any;
  logic              w_pick_data;
  logic              w_store;
  logic              w_skip_cs;
  logic [3:0]        w_be;
  logic [ADDR_W-1:0] w_addr;

`ifdef MEM_ROUND_ROBIN_EN
  logic r_last_data;
  // On a tie the requester not granted last time wins.
  assign w_pick_data = D_REQ & (~I_REQ | ~r_last_data);
`else
  assign w_pick_data = D_REQ;
`endif

  assign w_any     = I_REQ | D_REQ;
  assign w_store   = w_pick_data & D_WE;
  assign w_be      = w_store ? D_BE : 4'hF;
  assign w_skip_cs = w_store & (D_BE == 4'h0);
  assign w_addr    = w_pick_data ? D_ADDR : I_ADDR;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_gnt_data <= 1'b0;
      r_cmd_we   <= 1'b0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
      r_m_csn    <= 1'b1;
      r_m_wen    <= 1'b1;
      r_m_be     <= 4'd0;
      r_m_addr   <= '0;
      r_m_dout   <= 32'd0;
`ifdef MEM_ROUND_ROBIN_EN
      r_last_data <= 1'b0;
`endif
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            // Memory pins are loaded here so they are valid throughout ACCESS.
            r_gnt_data <= w_pick_data;
            r_cmd_we   <= w_store;
            r_m_addr   <= w_addr;
            r_m_be     <= w_be;
            r_m_csn    <= w_skip_cs;
            r_m_wen    <= ~(w_store & ~w_skip_cs);
            if (w_store) r_m_dout <= D_WDATA;
`ifdef MEM_ROUND_ROBIN_EN
            r_last_data <= w_pick_data;
`endif
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_m_csn <= 1'b1;
          r_m_wen <= 1'b1;
          if (r_cmd_we) begin
            r_d_ack <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= LAT_RELOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            if (r_gnt_data) r_d_rdata <= M_DIN;
            else            r_i_rdata <= M_DIN;
            r_i_ack <= ~r_gnt_data;
            r_d_ack <= r_gnt_data;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign I_RDATA     = r_i_rdata;
  assign I_ACK       = r_i_ack;
  assign D_RDATA     = r_d_rdata;
  assign D_ACK       = r_d_ack;
  assign M_CSN       = r_m_csn;
  assign M_WEN       = r_m_wen;
  assign M_BE        = r_m_be;
  assign M_ADDR      = r_m_addr;
  assign M_DOUT      = r_m_dout;
  assign BUSY        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15), a timeline model
// checked every cycle, and directed transactions with literal expectations.
module tb_mem_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [31:0] memw(input logic [AW-1:0] a);
    if (a == 12'h010) return 32'h00A00093;
    return {4'h5, a, 4'hA, ~a};
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req   [N];
  logic [AW-1:0] i_addr  [N];
  logic [31:0]   i_rdata [N];
  logic          i_ack   [N];
  logic          d_req   [N];
  logic          d_we    [N];
  logic [3:0]    d_be    [N];
  logic [AW-1:0] d_addr  [N];
  logic [31:0]   d_wdata [N];
  logic [31:0]   d_rdata [N];
  logic          d_ack   [N];
  logic          m_csn   [N];
  logic          m_wen   [N];
  logic [3:0]    m_be    [N];
  logic [AW-1:0] m_addr  [N];
  logic [31:0]   m_dout  [N];
  logic [31:0]   m_din   [N];
  logic          busy    [N];
  logic [1:0]    dbg     [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(lat_of(g))) u_dut (
      .CLK(clk), .RST(rst),
      .I_REQ(i_req[g]), .I_ADDR(i_addr[g]), .I_RDATA(i_rdata[g]), .I_ACK(i_ack[g]),
      .D_REQ(d_req[g]), .D_WE(d_we[g]), .D_BE(d_be[g]), .D_ADDR(d_addr[g]),
      .D_WDATA(d_wdata[g]), .D_RDATA(d_rdata[g]), .D_ACK(d_ack[g]),
      .M_CSN(m_csn[g]), .M_WEN(m_wen[g]), .M_BE(m_be[g]), .M_ADDR(m_addr[g]),
      .M_DOUT(m_dout[g]), .M_DIN(m_din[g]), .BUSY(busy[g]), .o_dbg_state(dbg[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  // Memory environment: answers a read exactly MEM_LAT cycles after its access cycle.
  bit            acc_v   [N];
  int            acc_c   [N];
  logic [AW-1:0] acc_a   [N];
  int            csn_cnt [N];
  logic [AW-1:0] wr_addr [N];
  logic [3:0]    wr_be   [N];
  logic [31:0]   wr_data [N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (m_csn[k] === 1'b0) begin
        csn_cnt[k]++;
        if (m_wen[k] === 1'b1) begin
          acc_v[k] = 1'b1;
          acc_c[k] = cyc;
          acc_a[k] = m_addr[k];
        end else begin
          wr_addr[k] = m_addr[k];
          wr_be[k]   = m_be[k];
          wr_data[k] = m_dout[k];
        end
      end
      m_din[k] = (acc_v[k] && cyc == acc_c[k] + lat_of(k)) ? memw(acc_a[k])
                                                           : (32'h0BAD0000 ^ 32'(cyc));
    end
  end

  // Transaction timeline model: one outstanding transaction per instance.
  bit            m_act  [N];
  int            m_t    [N];
  int            m_ackc [N];
  bit            m_data [N];
  bit            m_we   [N];
  bit            m_lastd[N];
  logic [3:0]    m_be_c [N];
  logic [AW-1:0] m_ad_c [N];
  logic [31:0]   m_wd_c [N];
  logic [AW-1:0] h_addr [N];
  logic [3:0]    h_be   [N];
  logic [31:0]   h_dout [N];
  logic [31:0]   h_ir   [N];
  logic [31:0]   h_dr   [N];
  bit            e_busy [N];
  bit            e_csn  [N];
  bit            e_wen  [N];
  bit            e_iack [N];
  bit            e_dack [N];

  always @(posedge clk) begin
    int c;
    int x;
    c = cyc;
    x = c + 1;
    for (int k = 0; k < N; k++) begin
      bit pd;
      bit acc;
      if (rst) begin
        m_act[k] = 1'b0; m_lastd[k] = 1'b0;
        h_addr[k] = '0; h_be[k] = 4'h0; h_dout[k] = 32'h0; h_ir[k] = 32'h0; h_dr[k] = 32'h0;
      end else if (!m_act[k] || c > m_ackc[k]) begin
        m_act[k] = 1'b0;
        if (i_req[k] || d_req[k]) begin
`ifdef MEM_ROUND_ROBIN_EN
          pd = d_req[k] && (!i_req[k] || !m_lastd[k]);
`else
          pd = d_req[k];
`endif
          m_lastd[k] = pd;
          m_act[k]   = 1'b1;
          m_t[k]     = c;
          m_data[k]  = pd;
          m_we[k]    = pd && d_we[k];
          m_be_c[k]  = m_we[k] ? d_be[k] : 4'hF;
          m_ad_c[k]  = pd ? d_addr[k] : i_addr[k];
          m_wd_c[k]  = d_wdata[k];
          m_ackc[k]  = c + (m_we[k] ? 2 : lat_of(k) + 2);
        end
      end
      acc       = m_act[k] && x == m_t[k] + 1;
      e_busy[k] = m_act[k] && x >= m_t[k] + 1 && x <= m_ackc[k];
      e_csn[k]  = !(acc && !(m_we[k] && m_be_c[k] == 4'h0));
      e_wen[k]  = !(acc && m_we[k] && m_be_c[k] != 4'h0);
      if (acc) begin
        h_addr[k] = m_ad_c[k];
        h_be[k]   = m_be_c[k];
        if (m_we[k]) h_dout[k] = m_wd_c[k];
      end
      e_iack[k] = m_act[k] && x == m_ackc[k] && !m_data[k];
      e_dack[k] = m_act[k] && x == m_ackc[k] && m_data[k];
      if (m_act[k] && x == m_ackc[k] && !m_we[k]) begin
        if (m_data[k]) h_dr[k] = memw(m_ad_c[k]);
        else           h_ir[k] = memw(m_ad_c[k]);
      end
    end
    cyc = x;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int k = 0; k < N; k++) begin
        check("busy",    k, busy[k],    e_busy[k]);
        check("m_csn",   k, m_csn[k],   e_csn[k]);
        check("m_wen",   k, m_wen[k],   e_wen[k]);
        check("m_addr",  k, m_addr[k],  h_addr[k]);
        check("m_be",    k, m_be[k],    h_be[k]);
        check("m_dout",  k, m_dout[k],  h_dout[k]);
        check("i_ack",   k, i_ack[k],   e_iack[k]);
        check("d_ack",   k, d_ack[k],   e_dack[k]);
        check("i_rdata", k, i_rdata[k], h_ir[k]);
        check("d_rdata", k, d_rdata[k], h_dr[k]);
      end
    end
  end

  task automatic fetch(input int k, input logic [AW-1:0] a, output int req_c, output int ack_c);
    @(negedge clk);
    i_req[k] = 1'b1; i_addr[k] = a; req_c = cyc; ack_c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (i_ack[k] === 1'b1) begin ack_c = cyc; break; end
    end
    i_req[k] = 1'b0;
    if (ack_c < 0) begin
      checks++; errors++;
      $display("FAIL fetch_timeout inst%0d addr %h: no I_ACK within 60 cycles", k, a);
    end
  endtask

  task automatic data(input int k, input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                      input logic [31:0] wd, output int req_c, output int ack_c);
    @(negedge clk);
    d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = a; d_wdata[k] = wd;
    req_c = cyc; ack_c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (d_ack[k] === 1'b1) begin ack_c = cyc; break; end
    end
    d_req[k] = 1'b0;
    if (ack_c < 0) begin
      checks++; errors++;
      $display("FAIL data_timeout inst%0d addr %h: no D_ACK within 60 cycles", k, a);
    end
  endtask

  initial begin
    int r, a, r2, a2, cs0;
    for (int k = 0; k < N; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_be[k] = 4'h0; d_addr[k] = '0; d_wdata[k] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 0, busy[0], 1'b0);
    check("rst_csn", 0, m_csn[0], 1'b1);
    check("rst_maddr", 0, m_addr[0], 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch with MEM_LAT=2: one chip-select cycle, ACK four cycles after the request.
    cs0 = csn_cnt[0];
    fetch(0, 12'h010, r, a);
    check("fetch_lat", 0, 32'(a - r), 32'd4);
    check("fetch_rdata", 0, i_rdata[0], 32'h00A00093);
    check("fetch_cs_cycles", 0, 32'(csn_cnt[0] - cs0), 32'd1);

    // Partial store.
    cs0 = csn_cnt[0];
    data(0, 1'b1, 4'b0011, 12'h204, 32'hDEADBEEF, r, a);
    check("store_lat", 0, 32'(a - r), 32'd2);
    check("store_addr", 0, wr_addr[0], 32'h204);
    check("store_be", 0, wr_be[0], 32'h3);
    check("store_data", 0, wr_data[0], 32'hDEADBEEF);
    check("store_cs_cycles", 0, 32'(csn_cnt[0] - cs0), 32'd1);

    // Load leaves I_RDATA alone.
    data(0, 1'b0, 4'h0, 12'h300, 32'h0, r, a);
    check("load_lat", 0, 32'(a - r), 32'd4);
    check("load_rdata", 0, d_rdata[0], 32'h5300ACFF);
    check("load_keeps_irdata", 0, i_rdata[0], 32'h00A00093);

    // Store with no byte enables never selects the memory.
    cs0 = csn_cnt[0];
    data(0, 1'b1, 4'h0, 12'h208, 32'hCAFEF00D, r, a);
    check("be0_lat", 0, 32'(a - r), 32'd2);
    check("be0_cs_cycles", 0, 32'(csn_cnt[0] - cs0), 32'd0);

    // First tie after a fetch grant: data goes first in both modes.
    fetch(0, 12'h020, r, a);
    fork
      fetch(0, 12'h040, r2, a2);
      data(0, 1'b1, 4'hF, 12'h100, 32'h12345678, r, a);
    join
    check("tie1_data_lat", 0, 32'(a - r), 32'd2);
    check("tie1_fetch_lat", 0, 32'(a2 - r2), 32'd7);
    check("tie1_rdata", 0, i_rdata[0], 32'h5040AFBF);

    // Second tie right after a lone data grant.
    data(0, 1'b0, 4'h0, 12'h300, 32'h0, r, a);
    fork
      fetch(0, 12'h008, r2, a2);
      data(0, 1'b1, 4'hC, 12'h104, 32'hA5A5A5A5, r, a);
    join
`ifdef MEM_ROUND_ROBIN_EN
    check("tie2_fetch_lat", 0, 32'(a2 - r2), 32'd4);
    check("tie2_data_lat", 0, 32'(a - r), 32'd7);
`else
    check("tie2_data_lat", 0, 32'(a - r), 32'd2);
    check("tie2_fetch_lat", 0, 32'(a2 - r2), 32'd7);
`endif
    check("tie2_rdata", 0, i_rdata[0], 32'h5008AFF7);

    // Reset during WAIT of a load abandons it.
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 12'h3F0;
    repeat (2) @(negedge clk);
    rst = 1'b1; d_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy", 0, busy[0], 1'b0);
    check("rstw_drdata", 0, d_rdata[0], 32'h0);
    check("rstw_irdata", 0, i_rdata[0], 32'h0);
    check("rstw_csn", 0, m_csn[0], 1'b1);
    check("rstw_wen", 0, m_wen[0], 1'b1);
    check("rstw_maddr", 0, m_addr[0], 32'h0);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("rstw_no_dack", 0, d_ack[0], 1'b0);
    end

    // Back-to-back fetches at the latency extremes.
    fetch(1, 12'h010, r, a);
    check("lat1_rdata_a", 1, i_rdata[1], 32'h00A00093);
    fetch(1, 12'h008, r2, a2);
    check("lat1_spacing", 1, 32'(a2 - a), 32'd4);
    check("lat1_rdata_b", 1, i_rdata[1], 32'h5008AFF7);
    fetch(2, 12'h010, r, a);
    check("lat15_first", 2, 32'(a - r), 32'd17);
    fetch(2, 12'h008, r2, a2);
    check("lat15_spacing", 2, 32'(a2 - a), 32'd18);
    check("lat15_rdata", 2, i_rdata[2], 32'h5008AFF7);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
